// File: rtl/frame_renderer_if.sv
// Game-state inputs and video/strobe outputs of frame_renderer.
// The slave modport is the renderer side. The master modport is the game/driver side.
interface frame_renderer_if;
    logic [9:0]  PADDLE_X_PIXEL;
    logic [9:0]  BALL_X_PIXEL;
    logic [9:0]  BALL_Y_PIXEL;
    logic [71:0] BLOCK_STATE;
    logic        START_UPDATE;
    logic        HSYNC;
    logic        VSYNC;
    logic [7:0]  RGB;

    modport master (
        output PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
        input  START_UPDATE, HSYNC, VSYNC, RGB
    );

    modport slave (
        input  PADDLE_X_PIXEL, BALL_X_PIXEL, BALL_Y_PIXEL, BLOCK_STATE,
        output START_UPDATE, HSYNC, VSYNC, RGB
    );
endinterface

// File: rtl/frame_renderer.sv
// SVGA raster + per-frame state snapshot + 2-stage RGB332 renderer; RGB/syncs lag counters by 2 cycles, no backpressure.
// Define BLOCK_OUTLINE_EN to leave a 1-pixel gap on the right and bottom edge of every block.
module frame_renderer #(
    parameter int H_VISIBLE    = 800,
    parameter int H_FRONT      = 40,
    parameter int H_SYNC       = 128,
    parameter int H_BACK       = 88,
    parameter int V_VISIBLE    = 600,
    parameter int V_FRONT      = 1,
    parameter int V_SYNC       = 4,
    parameter int V_BACK       = 23,
    parameter int BLOCK_X0     = 16,
    parameter int BLOCK_Y0     = 64,
    parameter int BALL_SIZE    = 8,
    parameter int PADDLE_LEN   = 64,
    parameter int PADDLE_Y     = 560,
    parameter int PADDLE_H     = 8,
    parameter int LEFT_WALL_X  = 8,
    parameter int RIGHT_WALL_X = 784,
    parameter int CEILING_Y    = 48,
    parameter int UPDATE_LEN   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    frame_renderer_if.slave  bus
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int WALL_W  = 8;

    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS   = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS   = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END  = 11'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [10:0] UPD_LEN = 11'(UPDATE_LEN);

    localparam logic [9:0] BX0      = 10'(BLOCK_X0);
    localparam logic [9:0] BY0      = 10'(BLOCK_Y0);
    localparam logic [9:0] BALL_SZ  = 10'(BALL_SIZE);
    localparam logic [9:0] PAD_LEN  = 10'(PADDLE_LEN);
    localparam logic [9:0] PAD_Y    = 10'(PADDLE_Y);
    localparam logic [9:0] PAD_H    = 10'(PADDLE_H);
    localparam logic [9:0] LWALL    = 10'(LEFT_WALL_X);
    localparam logic [9:0] RWALL    = 10'(RIGHT_WALL_X);
    localparam logic [9:0] CEIL     = 10'(CEILING_Y);
    localparam logic [9:0] WALL_SZ  = 10'(WALL_W);
    localparam logic [9:0] CEIL_END = 10'(RIGHT_WALL_X + WALL_W);

    logic [10:0] h_count, v_count, h_next, v_next;

    logic [9:0]  paddle_sh, ball_x_sh, ball_y_sh;
    logic [71:0] blocks_sh;

    logic [9:0]  x, y;
    logic        in_ball, in_paddle, in_wall, in_field;
    logic [3:0]  blk_col;
    logic [5:0]  blk_row;
    logic [6:0]  blk_idx;

    logic        s1_ball, s1_paddle, s1_wall, s1_field, s1_visible, s1_hsync, s1_vsync;
    logic [6:0]  s1_idx;
    logic [2:0]  s1_row;
    logic [7:0]  pixel;

    function automatic logic [7:0] row_colour(input logic [2:0] row);
        case (row)
            3'd0:    row_colour = 8'hE0;
            3'd1:    row_colour = 8'hEC;
            3'd2:    row_colour = 8'hFC;
            3'd3:    row_colour = 8'h1C;
            3'd4:    row_colour = 8'h1F;
            3'd5:    row_colour = 8'hE3;
            default: row_colour = 8'h00;
        endcase
    endfunction

    // Raster counters
    always_comb begin
        h_next = h_count + 11'd1;
        v_next = v_count;
        if (h_count == H_LAST) begin
            h_next = '0;
            v_next = (v_count == V_LAST) ? '0 : v_count + 11'd1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            h_count          <= '0;
            v_count          <= '0;
            bus.START_UPDATE <= 1'b0;
        end else begin
            h_count          <= h_next;
            v_count          <= v_next;
            bus.START_UPDATE <= (v_next == V_VIS) && (h_next != 11'd0) && (h_next <= UPD_LEN);
        end
    end

    // Game state is frozen at the top of vertical blanking so a frame never tears.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            paddle_sh <= 10'd370;
            ball_x_sh <= 10'd395;
            ball_y_sh <= 10'd400;
            blocks_sh <= '1;
        end else if (h_count == 11'd0 && v_count == V_VIS) begin
            paddle_sh <= bus.PADDLE_X_PIXEL;
            ball_x_sh <= bus.BALL_X_PIXEL;
            ball_y_sh <= bus.BALL_Y_PIXEL;
            blocks_sh <= bus.BLOCK_STATE;
        end
    end

    // Offsets wrap modulo 1024, so pixels left of / above an object fail the range test.
    always_comb begin
        x         = h_count[9:0];
        y         = v_count[9:0];
        in_ball   = ((x - ball_x_sh) < BALL_SZ) && ((y - ball_y_sh) < BALL_SZ);
        in_paddle = ((x - paddle_sh) < PAD_LEN) && ((y - PAD_Y) < PAD_H);
        in_wall   = ((y >= CEIL) && (((x - LWALL) < WALL_SZ) || ((x - RWALL) < WALL_SZ)))
                 || (((y - CEIL) < WALL_SZ) && (x >= LWALL) && (x < CEIL_END));
        blk_col   = 4'((x - BX0) >> 6);
        blk_row   = 6'((y - BY0) >> 4);
        in_field  = (blk_col < 4'd12) && (blk_row < 6'd6);
`ifdef BLOCK_OUTLINE_EN
        if ((((x - BX0) & 10'h03F) == 10'h03F) || (((y - BY0) & 10'h00F) == 10'h00F))
            in_field = 1'b0;
`endif
        blk_idx   = 7'(blk_row[2:0]) * 7'd12 + 7'(blk_col);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            s1_ball    <= 1'b0;
            s1_paddle  <= 1'b0;
            s1_wall    <= 1'b0;
            s1_field   <= 1'b0;
            s1_idx     <= '0;
            s1_row     <= '0;
            s1_visible <= 1'b0;
            s1_hsync   <= 1'b0;
            s1_vsync   <= 1'b0;
        end else begin
            s1_ball    <= in_ball;
            s1_paddle  <= in_paddle;
            s1_wall    <= in_wall;
            s1_field   <= in_field;
            s1_idx     <= in_field ? blk_idx : 7'd0;
            s1_row     <= blk_row[2:0];
            s1_visible <= (h_count < H_VIS) && (v_count < V_VIS);
            s1_hsync   <= (h_count >= HS_BEG) && (h_count < HS_END);
            s1_vsync   <= (v_count >= VS_BEG) && (v_count < VS_END);
        end
    end

    always_comb begin
        pixel = 8'h00;
        if (s1_visible) begin
            if (s1_ball)
                pixel = 8'hFF;
            else if (s1_paddle)
                pixel = 8'hB6;
            else if (s1_wall)
                pixel = 8'h03;
            else if (s1_field && blocks_sh[s1_idx])
                pixel = row_colour(s1_row);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.RGB   <= 8'h00;
            bus.HSYNC <= 1'b0;
            bus.VSYNC <= 1'b0;
        end else begin
            bus.RGB   <= pixel;
            bus.HSYNC <= s1_hsync;
            bus.VSYNC <= s1_vsync;
        end
    end
endmodule

// File: tb/tb_frame_renderer.sv
// Bench for frame_renderer on a shrunken raster: per-cycle reference model plus hand-computed pixel/strobe checks.
module tb_frame_renderer;
    localparam int HV = 152, HF = 4, HS = 12, HB = 8, HT = HV + HF + HS + HB;   // 176
    localparam int VV = 72,  VF = 1, VS = 4,  VB = 3, VT = VV + VF + VS + VB;   // 80
    localparam int FR = HT * VT;                                                // 14080
    localparam int BX0 = 16, BY0 = 32, BSZ = 8, PLEN = 64, PY = 56, PH = 8;
    localparam int LW = 8, RW = 144, CEIL = 16, ULEN = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;

    frame_renderer_if bus();

    frame_renderer #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .BLOCK_X0(BX0), .BLOCK_Y0(BY0), .BALL_SIZE(BSZ), .PADDLE_LEN(PLEN),
        .PADDLE_Y(PY), .PADDLE_H(PH), .LEFT_WALL_X(LW), .RIGHT_WALL_X(RW),
        .CEILING_Y(CEIL), .UPDATE_LEN(ULEN)
    ) dut (
        .CLK(clk),
        .RESET(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;          // cycles since reset release = raster position index
    int su_cnt = 0;

    int          sh_px, sh_bx, sh_by;
    logic [71:0] sh_blk;

    always @(posedge clk or posedge rst) begin
        if (rst) n = 0;
        else     n = n + 1;
    end

    function automatic logic [7:0] model_pixel(input int x, input int y);
        int col, row;
        logic [7:0] colours [6];
        colours = '{8'hE0, 8'hEC, 8'hFC, 8'h1C, 8'h1F, 8'hE3};
        if (x >= HV || y >= VV) return 8'h00;
        if (x >= sh_bx && x < sh_bx + BSZ && y >= sh_by && y < sh_by + BSZ) return 8'hFF;
        if (x >= sh_px && x < sh_px + PLEN && y >= PY && y < PY + PH) return 8'hB6;
        if (y >= CEIL && ((x >= LW && x < LW + 8) || (x >= RW && x < RW + 8))) return 8'h03;
        if (y >= CEIL && y < CEIL + 8 && x >= LW && x < RW + 8) return 8'h03;
        if (x >= BX0 && y >= BY0) begin
            col = (x - BX0) / 64;
            row = (y - BY0) / 16;
            if (col < 12 && row < 6 && sh_blk[row * 12 + col]) begin
`ifdef BLOCK_OUTLINE_EN
                if ((x - BX0) % 64 == 63 || (y - BY0) % 16 == 15) return 8'h00;
`endif
                return colours[row];
            end
        end
        return 8'h00;
    endfunction

    logic [7:0] e_rgb;
    logic       e_hs, e_vs, e_su;
    int         mh, mv, mx, my;

    always @(negedge clk) begin
        if (rst) begin
            e_rgb = 8'h00; e_hs = 1'b0; e_vs = 1'b0; e_su = 1'b0;
            sh_px = 370; sh_bx = 395; sh_by = 400; sh_blk = '1;
        end else begin
            mh   = n % HT;
            mv   = (n / HT) % VT;
            e_su = (mv == VV && mh >= 1 && mh <= ULEN);
            if (n >= 2) begin
                mx    = (n - 2) % HT;
                my    = ((n - 2) / HT) % VT;
                e_rgb = model_pixel(mx, my);
                e_hs  = (mx >= HV + HF && mx < HV + HF + HS);
                e_vs  = (my >= VV + VF && my < VV + VF + VS);
            end else begin
                e_rgb = 8'h00; e_hs = 1'b0; e_vs = 1'b0;
            end
            if (mh == 0 && mv == VV) begin
                sh_px  = int'(bus.PADDLE_X_PIXEL);
                sh_bx  = int'(bus.BALL_X_PIXEL);
                sh_by  = int'(bus.BALL_Y_PIXEL);
                sh_blk = bus.BLOCK_STATE;
            end
        end
        checks++;
        if ({bus.RGB, bus.HSYNC, bus.VSYNC, bus.START_UPDATE} !== {e_rgb, e_hs, e_vs, e_su}) begin
            errors++;
            $display("FAIL model n=%0d got rgb=%02h hs=%b vs=%b su=%b expected rgb=%02h hs=%b vs=%b su=%b",
                     n, bus.RGB, bus.HSYNC, bus.VSYNC, bus.START_UPDATE, e_rgb, e_hs, e_vs, e_su);
        end
        if (!rst && bus.START_UPDATE === 1'b1) su_cnt++;
    end

    task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h at n=%0d", name, act, exp, n);
        end
    endtask

    task automatic wait_n(input int target);
        int guard = 0;
        while (n < target && guard < 60000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL wait_n reached n=%0d expected n=%0d", n, target);
        end
    endtask

    task automatic expect_px(input int f, input int x, input int y, input logic [7:0] exp, input string name);
        wait_n(f * FR + y * HT + x + 2);
        check_val(name, bus.RGB, exp);
    endtask

    task automatic expect_sig(input int target, input int which, input logic exp, input string name);
        logic v;
        wait_n(target);
        case (which)
            0:       v = bus.HSYNC;
            1:       v = bus.VSYNC;
            default: v = bus.START_UPDATE;
        endcase
        check_val(name, {7'd0, v}, {7'd0, exp});
    endtask

    logic [7:0] outline_px;

    initial begin
        bus.PADDLE_X_PIXEL = 10'd30;
        bus.BALL_X_PIXEL   = 10'd100;
        bus.BALL_Y_PIXEL   = 10'd54;
        bus.BLOCK_STATE    = 72'd0;
        bus.BLOCK_STATE[13] = 1'b1;
`ifdef BLOCK_OUTLINE_EN
        outline_px = 8'h00;
`else
        outline_px = 8'hE0;
`endif
        #1 rst = 1'b1;
        @(negedge clk);
        check_val("reset_rgb", bus.RGB, 8'h00);
        check_val("reset_syncs", {5'd0, bus.START_UPDATE, bus.HSYNC, bus.VSYNC}, 8'h00);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Frame 0 renders the power-up shadows: all blocks alive, ball and paddle off-screen.
        expect_sig(157, 0, 1'b0, "hsync_before");
        expect_sig(158, 0, 1'b1, "hsync_first");
        expect_sig(169, 0, 1'b1, "hsync_last");
        expect_sig(170, 0, 1'b0, "hsync_after");
        expect_px(0, 60, 10, 8'h00, "f0_above_ceiling");
        expect_px(0, 60, 20, 8'h03, "f0_ceiling");
        expect_px(0, 20, 40, 8'hE0, "f0_block_r0c0");
        expect_px(0, 79, 40, outline_px, "f0_block_right_edge");
        expect_px(0, 150, 40, 8'h03, "f0_right_wall_over_block");
        expect_px(0, 155, 40, 8'h00, "f0_hblank");
        expect_px(0, 8, 50, 8'h03, "f0_left_wall");
        expect_px(0, 80, 50, 8'hEC, "f0_block_r1c1");
        expect_sig(73 * HT + 1, 1, 1'b0, "vsync_before");
        expect_sig(73 * HT + 2, 1, 1'b1, "vsync_first");

        // Frame 1: ball (100,54), paddle 30, only block 13; ball X changes mid-frame.
        wait_n(FR + 20 * HT);
        #2 bus.BALL_X_PIXEL = 10'd40;
`ifdef BLOCK_OUTLINE_EN
        outline_px = 8'h00;
`else
        outline_px = 8'hEC;
`endif
        expect_px(1, 16, 32, 8'h00, "f1_dead_block0");
        expect_px(1, 80, 48, 8'hEC, "f1_block13");
        expect_px(1, 143, 48, outline_px, "f1_block13_edge");
        expect_px(1, 100, 54, 8'hFF, "f1_ball_unchanged");
        expect_px(1, 108, 54, 8'hEC, "f1_past_ball");
        expect_px(1, 93, 56, 8'hB6, "f1_paddle_last");
        expect_px(1, 94, 56, 8'hEC, "f1_past_paddle");
        expect_px(1, 107, 61, 8'hFF, "f1_ball_corner");
        expect_px(1, 30, 63, 8'hB6, "f1_paddle_first");

        // Frame 2: ball now at (40,54), overlapping the paddle.
        expect_px(2, 40, 54, 8'hFF, "f2_ball_moved");
        expect_px(2, 100, 54, 8'hEC, "f2_old_ball_gone");
        expect_px(2, 40, 58, 8'hFF, "f2_ball_over_paddle");
        expect_px(2, 48, 58, 8'hB6, "f2_paddle_past_ball");

        // Mid-frame reset.
        wait_n(2 * FR + 62 * HT + 80);
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("rst_counters_zero", {7'd0, (dut.h_count == 11'd0 && dut.v_count == 11'd0)}, 8'h01);
            check_val("rst_rgb", bus.RGB, 8'h00);
        end
        #2 rst = 1'b0;

        expect_px(0, 20, 40, 8'hE0, "post_rst_blocks_restored");
        expect_sig(VV * HT, 2, 1'b0, "su_before");
        expect_sig(VV * HT + 1, 2, 1'b1, "su_first");
        expect_sig(VV * HT + ULEN, 2, 1'b1, "su_last");
        expect_sig(VV * HT + ULEN + 1, 2, 1'b0, "su_after");
        check_val("su_total_cycles", 8'(su_cnt), 8'd24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at n=%0d", n);
        $fatal(1, "watchdog");
    end
endmodule
